// File: rtl/id_ex_skid_reg.sv
// ID->EX pipeline register with a two-entry (main + skid) valid/ready buffer.
// Flush is synchronous. Control outputs are gated so that a bubble cannot write state.
module id_ex_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int ALU_W  = 2,
  parameter int COND_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              regw_in,
  input  logic              flagw_in,
  input  logic              memw_in,
  input  logic              memr_in,
  input  logic              branch_in,
  input  logic              imm_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [ALU_W-1:0]  alu_ctrl_in,
  input  logic [COND_W-1:0] cond_sel_in,
  input  logic [REG_W-1:0]  rs1_in,
  input  logic [REG_W-1:0]  rs2_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              regw_out,
  output logic              flagw_out,
  output logic              memw_out,
  output logic              memr_out,
  output logic              branch_out,
  output logic              imm_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ALU_W-1:0]  alu_ctrl_out,
  output logic [COND_W-1:0] cond_sel_out,
  output logic [REG_W-1:0]  rs1_out,
  output logic [REG_W-1:0]  rs2_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int CTRL_W = 6;
  localparam int PAY_W  = CTRL_W + 2*DATA_W + ALU_W + COND_W + 3*REG_W;

  logic [PAY_W-1:0]  w_in_pay;
  logic [PAY_W-1:0]  r_main_pay;
  logic [PAY_W-1:0]  r_skid_pay;
  logic              r_main_valid;
  logic              r_skid_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [CTRL_W-1:0] w_ctrl_gated;
  logic              w_acc;
  logic              w_drn;

  // Control bits occupy the top CTRL_W bits so flush can clear them as one slice.
  assign w_in_pay = {regw_in, flagw_in, memw_in, memr_in, branch_in, imm_in,
                     a_in, b_in, alu_ctrl_in, cond_sel_in, rs1_in, rs2_in, rd_in};

  assign in_ready   = !r_skid_valid;
  assign out_valid  = r_main_valid;
  assign bubble_cnt = r_bubble_cnt;
  assign w_acc      = in_valid & !r_skid_valid;
  assign w_drn      = r_main_valid & out_ready;

  assign {w_main_ctrl, a_out, b_out, alu_ctrl_out, cond_sel_out,
          rs1_out, rs2_out, rd_out} = r_main_pay;

  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_gate
      assign w_ctrl_gated[gi] = w_main_ctrl[gi] & r_main_valid;
    end
  endgenerate

  assign {regw_out, flagw_out, memw_out, memr_out, branch_out, imm_out} = w_ctrl_gated;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_pay   <= '0;
      r_skid_pay   <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_pay[PAY_W-1 -: CTRL_W] <= '0;
      r_skid_pay[PAY_W-1 -: CTRL_W] <= '0;
    end else if (!r_main_valid || w_drn) begin
      if (r_skid_valid) begin
        r_main_pay   <= r_skid_pay;
        r_main_valid <= 1'b1;
        r_skid_valid <= w_acc;
        if (w_acc) begin
          r_skid_pay <= w_in_pay;
        end
      end else if (w_acc) begin
        r_main_pay   <= w_in_pay;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_acc) begin
      // Main is stalled: park the accepted bundle; in_ready drops next cycle.
      r_skid_pay   <= w_in_pay;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (out_ready && !r_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Scoreboard bench for id_ex_skid_reg: the reference is a FIFO of accepted bundles
// (capacity two); the monitor compares the head against the outputs every valid cycle.
module tb_id_ex_skid_reg;

  typedef struct packed {
    logic        regw, flagw, memw, memr, branch, imm;
    logic [31:0] a, b;
    logic [1:0]  alu, cond;
    logic [3:0]  rs1, rs2, rd;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  item_t       cur = '0;
  logic        regw_out, flagw_out, memw_out, memr_out, branch_out, imm_out;
  logic [31:0] a_out, b_out;
  logic [1:0]  alu_ctrl_out, cond_sel_out;
  logic [3:0]  rs1_out, rs2_out, rd_out;
  logic [1:0]  bubble_cnt;

  item_t q[$];
  int    occ_now = 0;
  int    bcnt_model = 0;
  bit    in_reset = 1'b1;
  bit    verbose = 1'b1;
  int    n_checks = 0;
  int    n_pass = 0;

  id_ex_skid_reg #(.DATA_W(32), .REG_W(4), .ALU_W(2), .COND_W(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .regw_in(cur.regw), .flagw_in(cur.flagw), .memw_in(cur.memw), .memr_in(cur.memr),
    .branch_in(cur.branch), .imm_in(cur.imm), .a_in(cur.a), .b_in(cur.b),
    .alu_ctrl_in(cur.alu), .cond_sel_in(cur.cond), .rs1_in(cur.rs1), .rs2_in(cur.rs2),
    .rd_in(cur.rd), .out_valid(out_valid), .out_ready(out_ready),
    .regw_out(regw_out), .flagw_out(flagw_out), .memw_out(memw_out), .memr_out(memr_out),
    .branch_out(branch_out), .imm_out(imm_out), .a_out(a_out), .b_out(b_out),
    .alu_ctrl_out(alu_ctrl_out), .cond_sel_out(cond_sel_out), .rs1_out(rs1_out),
    .rs2_out(rs2_out), .rd_out(rd_out), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of stimulus; the model accepts when the FIFO has room.
  task automatic drive(input bit v, input bit r, input bit fl, input bit use_a,
                       input logic [31:0] a, input bit set_regw);
    item_t it;
    @(negedge clk);
    it = item_t'({$urandom, $urandom, $urandom});
    if (use_a) it.a = a;
    if (set_regw) it.regw = 1'b1;
    cur = it;
    in_valid = v;
    out_ready = r;
    flush = fl;
    #1;
    if (v && occ_now < 2 && !fl) q.push_back(it);
  endtask

  // Monitor: state checks just after the edge, payload check and pop before the next edge.
  initial begin
    item_t act;
    forever begin
      @(posedge clk);
      #1;
      occ_now = q.size();
      if (!in_reset) begin
        check("out_valid", 128'(out_valid), 128'(occ_now > 0));
        check("in_ready", 128'(in_ready), 128'(occ_now < 2));
        check("bubble_cnt", 128'(bubble_cnt), 128'(bcnt_model));
        if (occ_now == 0)
          check("bubble_gate", 128'({regw_out, flagw_out, memw_out, memr_out, branch_out, imm_out}), 128'(0));
      end
      #6;
      if (!in_reset) begin
        if (occ_now > 0) begin
          act = {regw_out, flagw_out, memw_out, memr_out, branch_out, imm_out,
                 a_out, b_out, alu_ctrl_out, cond_sel_out, rs1_out, rs2_out, rd_out};
          check("payload", 128'(act), 128'(q[0]));
          if (out_ready) begin
            if (verbose) $display("xfer a=%h b=%h rd=%0d regw=%b", act.a, act.b, act.rd, act.regw);
            void'(q.pop_front());
          end
        end else if (out_ready && bcnt_model < 3) begin
          bcnt_model++;
        end
        if (flush) q.delete();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_a_out", 128'(a_out), 128'(0));
    check("rst_bubble", 128'(bubble_cnt), 128'(0));
    reset = 1'b0;
    in_reset = 1'b0;

    // Streaming 0x10..0x12
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 32'h10 + i, 0);
    repeat (2) drive(0, 1, 0, 0, 0, 0);

    // Stall: 0x20 in main, 0x21 into skid, 0x22 refused
    drive(1, 0, 0, 1, 32'h20, 0);
    drive(1, 0, 0, 1, 32'h21, 0);
    drive(1, 0, 0, 1, 32'h22, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0, 0);

    // Flush with both entries full and a new input present
    drive(1, 0, 0, 1, 32'h30, 1);
    drive(1, 0, 0, 1, 32'h31, 1);
    drive(1, 0, 1, 1, 32'h32, 1);
    // Flush while draining and accepting in the same cycle
    drive(1, 0, 0, 1, 32'h33, 1);
    drive(1, 1, 1, 1, 32'h34, 1);
    repeat (6) drive(0, 1, 0, 0, 0, 0);

    // Async reset between edges while stalled with both entries full
    drive(1, 0, 0, 1, 32'h40, 1);
    drive(1, 0, 0, 1, 32'h41, 1);
    @(posedge clk);
    #3;
    in_reset = 1'b1;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_regw_out", 128'(regw_out), 128'(0));
    check("arst_a_out", 128'(a_out), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(1));
    check("arst_bubble", 128'(bubble_cnt), 128'(0));
    q.delete();
    bcnt_model = 0;
    occ_now = 0;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    in_reset = 1'b0;
    repeat (2) drive(0, 1, 0, 0, 0, 0);

    // Random traffic
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, 0, 0, 0);
    repeat (4) drive(0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("drained", 128'(q.size()), 128'(0));
    check("final_out_valid", 128'(out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
